// File: rtl/serial_adder.sv
// Bit-serial two's-complement adder: one full-adder bit per clock, LSB first.
// Start/done handshake; sum, cout and overflow are published only at completion.
module serial_adder #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   shift_a_q, shift_a_d;
  logic [WIDTH-1:0]   shift_b_q, shift_b_d;
  // Holds the low WIDTH-1 result bits; the MSB joins them on the final edge.
  logic [WIDTH-2:0]   shift_s_q, shift_s_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;

  logic               bit_s, bit_c;
  logic [WIDTH-1:0]   acc;

  assign bit_s = shift_a_q[0] ^ shift_b_q[0] ^ carry_q;
  assign bit_c = (shift_a_q[0] & shift_b_q[0]) | (shift_a_q[0] & carry_q) |
                 (shift_b_q[0] & carry_q);
  assign acc   = {bit_s, shift_s_q};

  always_comb begin
    state_d   = state_q;
    shift_a_d = shift_a_q;
    shift_b_d = shift_b_q;
    shift_s_d = shift_s_q;
    carry_d   = carry_q;
    count_d   = count_q;
    sum_d     = sum_q;
    cout_d    = cout_q;
    ovf_d     = ovf_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          shift_a_d = a;
          shift_b_d = b;
          carry_d   = cin;
          count_d   = '0;
          state_d   = StBusy;
        end else begin
          state_d   = StIdle;
        end
      end
      StBusy: begin
        shift_a_d = {1'b0, shift_a_q[WIDTH-1:1]};
        shift_b_d = {1'b0, shift_b_q[WIDTH-1:1]};
        shift_s_d = acc[WIDTH-1:1];
        carry_d   = bit_c;
        count_d   = count_q + CNT_W'(1);
        if (count_q == CNT_W'(WIDTH - 1)) begin
          // carry_q is the carry into the MSB here, bit_c the carry out of it.
          sum_d   = acc;
          cout_d  = bit_c;
          ovf_d   = carry_q ^ bit_c;
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      shift_a_q <= '0;
      shift_b_q <= '0;
      shift_s_q <= '0;
      carry_q   <= 1'b0;
      count_q   <= '0;
      sum_q     <= '0;
      cout_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_a_q <= shift_a_d;
      shift_b_q <= shift_b_d;
      shift_s_q <= shift_s_d;
      carry_q   <= carry_d;
      count_q   <= count_d;
      sum_q     <= sum_d;
      cout_q    <= cout_d;
      ovf_q     <= ovf_d;
    end
  end

  assign busy     = (state_q == StBusy);
  assign done     = (state_q == StDone);
  assign sum      = sum_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: latency, handshake, carry/overflow corners,
// ignored start while busy and reset abort.
module tb_serial_adder;

  localparam int unsigned WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;

  int checks;
  int errors;

  serial_adder #(
    .WIDTH (WIDTH),
    .CNT_W (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .cout     (cout),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present operands with start for one accept edge; returns #1 after that edge.
  task automatic issue(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib, input logic ic);
    a     = ia;
    b     = ib;
    cin   = ic;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Edges from accept until done, and cycles seen with busy high, bounded.
  task automatic wait_done(output int lat, output int busy_cnt);
    lat      = 0;
    busy_cnt = 0;
    while (!done && lat < 20) begin
      if (busy) busy_cnt++;
      step();
      lat++;
    end
  endtask

  task automatic op(input string tag, input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                    input logic ic, input logic [WIDTH-1:0] es, input logic ec,
                    input logic eo);
    int lat, bc;
    issue(ia, ib, ic);
    wait_done(lat, bc);
    check({tag, "_lat"}, lat, 8);
    check({tag, "_sum"}, sum, es);
    check({tag, "_cout"}, cout, ec);
    check({tag, "_ovf"}, overflow, eo);
  endtask

  initial begin
    int lat, bc, dcnt;
    logic [WIDTH-1:0] cap;
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    a      = '0;
    b      = '0;
    cin    = 1'b0;
    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    check("rst_ovf", overflow, 0);
    rst_n = 1'b1;
    step();

    // 1: basic add, latency and busy length
    issue(8'd10, 8'd5, 1'b0);
    check("t1_busy_after_accept", busy, 1);
    wait_done(lat, bc);
    check("t1_lat", lat, 8);
    check("t1_busy_cycles", bc, 8);
    check("t1_sum", sum, 15);
    check("t1_cout", cout, 0);
    check("t1_ovf", overflow, 0);
    check("t1_busy_in_done", busy, 0);

    // 2: back-to-back issue in the DONE cycle
    issue(8'd20, 8'd13, 1'b0);
    check("t2_no_gap_busy", busy, 1);
    check("t2_no_gap_done", done, 0);
    check("t2_sum_held", sum, 15);
    wait_done(lat, bc);
    check("t2_lat", lat, 8);
    check("t2_sum", sum, 33);
    step();
    check("t2_done_pulse", done, 0);
    step();
    check("t2_idle_hold", sum, 33);

    // 3/4: carry and overflow corners
    op("t3a", 8'd255, 8'd1, 1'b0, 8'd0, 1'b1, 1'b0);
    op("t3b", 8'd255, 8'd0, 1'b1, 8'd0, 1'b1, 1'b0);
    op("t4a", 8'd127, 8'd1, 1'b0, 8'd128, 1'b0, 1'b1);
    op("t4b", 8'd128, 8'd128, 1'b0, 8'd0, 1'b1, 1'b1);
    step();

    // 5: start while busy is ignored
    issue(8'd10, 8'd5, 1'b0);
    step();
    step();
    issue(8'd1, 8'd1, 1'b1);
    dcnt = 0;
    cap  = '0;
    for (int i = 0; i < 15; i++) begin
      if (done) begin
        dcnt++;
        cap = sum;
      end
      step();
    end
    check("t5_done_count", dcnt, 1);
    check("t5_sum", cap, 15);
    check("t5_idle", busy, 0);

    // 6: reset mid-operation aborts without done
    issue(8'd10, 8'd5, 1'b1);
    step();
    step();
    step();
    check("t6_busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    check("t6_busy", busy, 0);
    check("t6_sum", sum, 0);
    check("t6_done", done, 0);
    #2;
    rst_n = 1'b1;
    dcnt = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (done || busy) dcnt++;
    end
    check("t6_quiet", dcnt, 0);
    op("t6b", 8'd50, 8'd70, 1'b0, 8'd120, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
